mem_port_arbiter: RTL

Shares the single 16-bit synchronous memory port between two requesters. Requester 0 is the CPU, which does instruction fetch and load/store. Requester 1 is the program loader/debug master, which replaces file preloading of the RAM. After reset the block is in a boot phase: only the loader is served and the CPU is held in reset. Once the loader signals completion, in-flight reads drain and the two masters are then served round-robin, one command per cycle.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_tag_pipe.sv | 38 +++
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the two-master memory port arbiter
package mem_arb_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      DRAIN = 2'd1,
      RUN   = 2'd2
   } arb_state_e;

   typedef logic master_id_t;

   localparam master_id_t M_CPU    = 1'b0;
   localparam master_id_t M_LOADER = 1'b1;

   typedef struct packed {
      logic       valid;
      master_id_t id;
   } rd_tag_t;

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// rtl/mem_arb_tag_pipe.sv - read-owner tag delay line aligned to memory read data
module mem_arb_tag_pipe
   import mem_arb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_valid,
   input  logic i_id,
   output logic o_valid,
   output logic o_id,
   output logic o_empty
);

   rd_tag_t r_stage [DEPTH];
   logic    w_pending;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
      end else begin
         r_stage[0] <= '{valid: i_valid, id: i_id};
         for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
   end

   // The last stage is returning this cycle, so only earlier stages count as outstanding.
   always_comb begin
      w_pending = 1'b0;
      for (int i = 0; i < DEPTH - 1; i++) w_pending = w_pending | r_stage[i].valid;
   end

   assign o_valid = r_stage[DEPTH-1].valid;
   assign o_id    = r_stage[DEPTH-1].id;
   assign o_empty = ~w_pending;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - boot-gated round-robin arbiter for one synchronous memory port
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH   = 12,
   parameter int DATA_WIDTH   = 16,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  m0_req,
   input  logic                  m0_we,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   output logic                  m0_gnt,
   output logic                  m0_rvalid,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   input  logic                  m1_req,
   input  logic                  m1_we,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   output logic                  m1_gnt,
   output logic                  m1_rvalid,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   input  logic                  boot_done,
   output logic                  cpu_hold,
   output logic                  mem_en,
   output logic                  mem_rd_en,
   output logic                  mem_wr_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_din,
   input  logic [DATA_WIDTH-1:0] mem_dout
);

   arb_state_e            r_state;
   arb_state_e            w_next_state;
   master_id_t            r_last_grant;
   logic                  r_cpu_hold;
   logic                  w_gnt0;
   logic                  w_gnt1;
   logic                  w_any;
   master_id_t            w_sel_id;
   logic                  w_sel_we;
   logic [ADDR_WIDTH-1:0] w_sel_addr;
   logic [DATA_WIDTH-1:0] w_sel_wdata;
   logic                  r_mem_en;
   logic                  r_mem_rd_en;
   logic                  r_mem_wr_en;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0] r_mem_din;
   logic                  w_ret_valid;
   logic                  w_ret_id;
   logic                  w_tags_empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= BOOT;
         r_cpu_hold   <= 1'b1;
         r_last_grant <= M_LOADER;
      end else begin
         r_state    <= w_next_state;
         r_cpu_hold <= (w_next_state != RUN);
         if (w_any) r_last_grant <= w_sel_id;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         BOOT:    if (boot_done) w_next_state = DRAIN;
         DRAIN:   if (w_tags_empty) w_next_state = RUN;
         default: w_next_state = RUN;
      endcase
   end

   // On contention the master that did not win last time goes first.
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      case (r_state)
         BOOT: w_gnt1 = m1_req;
         RUN: begin
            if (m0_req && m1_req) begin
               w_gnt0 = (r_last_grant == M_LOADER);
               w_gnt1 = (r_last_grant == M_CPU);
            end else begin
               w_gnt0 = m0_req;
               w_gnt1 = m1_req;
            end
         end
         default: begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
         end
      endcase
   end

   assign w_any       = w_gnt0 | w_gnt1;
   assign w_sel_id    = w_gnt1 ? M_LOADER : M_CPU;
   assign w_sel_we    = w_gnt1 ? m1_we    : m0_we;
   assign w_sel_addr  = w_gnt1 ? m1_addr  : m0_addr;
   assign w_sel_wdata = w_gnt1 ? m1_wdata : m0_wdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_mem_en    <= 1'b0;
         r_mem_rd_en <= 1'b0;
         r_mem_wr_en <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_din   <= '0;
      end else begin
         r_mem_en    <= w_any;
         r_mem_rd_en <= w_any & ~w_sel_we;
         r_mem_wr_en <= w_any & w_sel_we;
         if (w_any) begin
            r_mem_addr <= w_sel_addr;
            r_mem_din  <= w_sel_wdata;
         end
      end
   end

   // One extra stage covers the registered command cycle ahead of the memory latency.
   mem_arb_tag_pipe #(
      .DEPTH (READ_LATENCY + 1)
   ) u_tag_pipe (
      .clk     (clk),
      .reset   (reset),
      .i_valid (w_any & ~w_sel_we),
      .i_id    (w_sel_id),
      .o_valid (w_ret_valid),
      .o_id    (w_ret_id),
      .o_empty (w_tags_empty)
   );

   assign m0_gnt    = w_gnt0;
   assign m1_gnt    = w_gnt1;
   assign m0_rvalid = w_ret_valid & (w_ret_id == M_CPU);
   assign m1_rvalid = w_ret_valid & (w_ret_id == M_LOADER);
   assign m0_rdata  = mem_dout;
   assign m1_rdata  = mem_dout;
   assign cpu_hold  = r_cpu_hold;
   assign mem_en    = r_mem_en;
   assign mem_rd_en = r_mem_rd_en;
   assign mem_wr_en = r_mem_wr_en;
   assign mem_addr  = r_mem_addr;
   assign mem_din   = r_mem_din;

endmodule
